// File: rtl/alu_control_mc.sv
// EX-stage ALU control decoder with HI/LO registers and an iterative
// multiply/divide sequencer that stalls the pipeline while it runs.
//
// state | meaning
// IDLE  | no mult/div in flight; decode, MTHI/MTLO, issue
// RUN   | one shift-add / shift-subtract iteration per cycle
// FIX   | sign correction, HI/LO written at the end of the cycle
// DONE  | result committed, done pulses, completed instr still in EX
module alu_control_mc #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [1:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       control_lines,
  output logic             use_hilo,
  output logic [WIDTH-1:0] hilo_out,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] m;
  logic             op_div;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;

  always_comb begin
    control_lines = 4'b1111;
    case (aluop)
      2'b00: control_lines = 4'b0010;
      2'b01: control_lines = 4'b0110;
      2'b10: begin
        case (funct)
          6'b100000, 6'b100001: control_lines = 4'b0010;
          6'b100010, 6'b100011: control_lines = 4'b0110;
          6'b100100:            control_lines = 4'b0000;
          6'b100101:            control_lines = 4'b0001;
          6'b100110:            control_lines = 4'b0011;
          6'b100111:            control_lines = 4'b1100;
          6'b101010:            control_lines = 4'b0111;
          6'b101011:            control_lines = 4'b0101;
          6'b000000:            control_lines = 4'b1000;
          6'b000010:            control_lines = 4'b1001;
          6'b000011:            control_lines = 4'b1010;
          6'b010000, 6'b010001, 6'b010010, 6'b010011,
          6'b011000, 6'b011001, 6'b011010, 6'b011011:
                                control_lines = 4'b1110;
          default:              control_lines = 4'b1111;
        endcase
      end
      default: control_lines = 4'b1111;
    endcase
  end

  logic f_md, f_hilo, issue, busy;
  assign f_md     = (aluop == 2'b10) && (funct[5:2] == 4'b0110);
  assign f_hilo   = (aluop == 2'b10) && (funct[5:2] == 4'b0100);
  assign issue    = valid && f_md;
  assign busy     = (state == RUN) || (state == FIX);
  assign use_hilo = f_hilo && !funct[0];
  assign hilo_out = (funct == 6'b010000) ? hi : lo;
  // HI/LO accesses while busy are already covered by busy itself.
  assign stall    = ((state == IDLE) && issue) || busy;

  // funct[0] set means the unsigned variant; funct[1] selects divide.
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_abs, rt_abs;
  assign rs_neg = !funct[0] && rs_val[WIDTH-1];
  assign rt_neg = !funct[0] && rt_val[WIDTH-1];
  assign rs_abs = rs_neg ? -rs_val : rs_val;
  assign rt_abs = rt_neg ? -rt_val : rt_val;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   q_fix, r_fix;

  // Multiply keeps {acc,q} as partial product / remaining multiplier;
  // divide keeps acc as partial remainder and shifts quotient bits into q.
  assign mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
  assign div_sh   = {acc, q[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, m};
  assign div_diff = div_sh[WIDTH-1:0] - m;
  assign prod     = {acc, q};
  assign prod_fix = neg_q ? -prod : prod;
  assign q_fix    = neg_q ? -q : q;
  assign r_fix    = neg_r ? -acc : acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      m        <= '0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            op_div   <= funct[1];
            neg_q    <= rs_neg ^ rt_neg;
            neg_r    <= rs_neg;
            div_zero <= (rt_val == '0);
            acc      <= '0;
            q        <= funct[1] ? rs_abs : rt_abs;
            m        <= funct[1] ? rt_abs : rs_abs;
            cnt      <= CNT_W'(WIDTH);
            state    <= RUN;
          end else if (valid && aluop == 2'b10 && funct == 6'b010001) begin
            hi <= rs_val;
          end else if (valid && aluop == 2'b10 && funct == 6'b010011) begin
            lo <= rs_val;
          end
        end
        RUN: begin
          if (op_div) begin
            acc <= div_ge ? div_diff : div_sh[WIDTH-1:0];
            q   <= {q[WIDTH-2:0], div_ge};
          end else begin
            acc <= mul_sum[WIDTH:1];
            q   <= {mul_sum[0], q[WIDTH-1:1]};
          end
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= FIX;
        end
        FIX: begin
          if (op_div) begin
            hi <= r_fix;
            // The plain divide by zero already leaves the dividend in HI.
            lo <= div_zero ? '1 : q_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_control_mc.sv
// Self-checking bench for alu_control_mc: decode sweep, directed and random
// mult/div against an arithmetic reference model, hazards, reset mid-op.
module tb_alu_control_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] rs_val, rt_val;
  logic [3:0]  control_lines;
  logic        use_hilo;
  logic [31:0] hilo_out;
  logic        stall;
  logic        done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done_cyc = 0;

  alu_control_mc #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .valid(valid), .aluop(aluop), .funct(funct),
    .rs_val(rs_val), .rt_val(rt_val), .control_lines(control_lines),
    .use_hilo(use_hilo), .hilo_out(hilo_out), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] exp_ctl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b1111;
    case (f)
      6'h20, 6'h21: return 4'b0010;
      6'h22, 6'h23: return 4'b0110;
      6'h24: return 4'b0000;
      6'h25: return 4'b0001;
      6'h26: return 4'b0011;
      6'h27: return 4'b1100;
      6'h2A: return 4'b0111;
      6'h2B: return 4'b0101;
      6'h00: return 4'b1000;
      6'h02: return 4'b1001;
      6'h03: return 4'b1010;
      6'h10, 6'h11, 6'h12, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: return 4'b1110;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] ehi, output logic [31:0] elo);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p = '0;
    case (f)
      6'h18: p = 64'(sa * sb);
      6'h19: p = {32'b0, a} * {32'b0, b};
      6'h1A: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          p[31:0]  = 32'(sa / sb);
          p[63:32] = 32'(sa % sb);
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    ehi = p[63:32];
    elo = p[31:0];
  endfunction

  task automatic go_idle();
    @(negedge clk);
    valid = 1'b0; aluop = 2'b00; funct = 6'h00;
  endtask

  // Issue one mult/div at the next falling edge and follow it to completion.
  task automatic do_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit flush);
    logic [31:0] ehi, elo;
    int t, nstall;
    bit seen;
    model(f, a, b, ehi, elo);
    @(negedge clk);
    valid = 1'b1; aluop = 2'b10; funct = f; rs_val = a; rt_val = b;
    #1;
    t = 0; nstall = 0; seen = 0;
    while (t < 100 && !seen) begin
      if (done) seen = 1;
      else begin
        if (stall) nstall++;
        @(negedge clk);
        if (flush) valid = 1'b0;
        #1;
        t++;
      end
    end
    last_done_cyc = cyc;
    checks++;
    if (!seen) begin
      errors++; $display("FAIL md_timeout f=%h got no done within 100 cycles", f);
    end
    checks++;
    if (t !== 34) begin
      errors++; $display("FAIL md_latency f=%h got %0d expected 34", f, t);
    end
    checks++;
    if (nstall !== 34) begin
      errors++; $display("FAIL md_stall_cycles f=%h got %0d expected 34", f, nstall);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL md_stall_at_done f=%h got %b expected 0", f, stall);
    end
    checks++;
    if (hi !== ehi) begin
      errors++; $display("FAIL md_hi f=%h a=%h b=%h got %h expected %h", f, a, b, hi, ehi);
    end
    checks++;
    if (lo !== elo) begin
      errors++; $display("FAIL md_lo f=%h a=%h b=%h got %h expected %h", f, a, b, lo, elo);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b0; aluop = 2'b00; funct = 6'h00; rs_val = '0; rt_val = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl got stall=%b done=%b expected 0 0", stall, done);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL reset_hilo got hi=%h lo=%h expected 0 0", hi, lo);
    end
    rst = 1'b0;
  endtask

  task automatic test_decode();
    go_idle();
    for (int op = 0; op < 4; op++) begin
      for (int f = 0; f < 64; f++) begin
        aluop = 2'(op); funct = 6'(f);
        #1;
        checks++;
        if (control_lines !== exp_ctl(2'(op), 6'(f))) begin
          errors++;
          $display("FAIL decode_ctl aluop=%b funct=%b got %b expected %b",
                   aluop, funct, control_lines, exp_ctl(2'(op), 6'(f)));
        end
        checks++;
        if (use_hilo !== (op == 2 && (f == 6'h10 || f == 6'h12))) begin
          errors++; $display("FAIL decode_use_hilo aluop=%b funct=%b got %b", aluop, funct, use_hilo);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_mult();
    do_md(6'h18, 32'hFFFF_FFFE, 32'h3, 0);
    do_md(6'h19, 32'hFFFF_FFFE, 32'h3, 0);
    go_idle();
  endtask

  task automatic test_div();
    do_md(6'h1A, 32'hFFFF_FFF9, 32'h2, 0);
    do_md(6'h1B, 32'h7, 32'h0, 0);
    do_md(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    go_idle();
  endtask

  task automatic test_hazard();
    logic [31:0] ehi, elo;
    int t;
    model(6'h18, 32'h0001_2345, 32'hFFFF_0101, ehi, elo);
    @(negedge clk);
    valid = 1'b1; aluop = 2'b10; funct = 6'h18; rs_val = 32'h0001_2345; rt_val = 32'hFFFF_0101;
    repeat (5) @(negedge clk);
    funct = 6'h12;
    #1;
    t = 5;
    while (!done && t < 100) begin
      checks++;
      if (stall !== 1'b1) begin
        errors++; $display("FAIL hazard_mflo_stall t=%0d got %b expected 1", t, stall);
      end
      @(negedge clk); #1; t++;
    end
    checks++;
    if (!done || t !== 34) begin
      errors++; $display("FAIL hazard_done t=%0d got done=%b expected done at 34", t, done);
    end
    @(negedge clk); #1;
    checks++;
    if (stall !== 1'b0 || use_hilo !== 1'b1 || hilo_out !== elo) begin
      errors++;
      $display("FAIL hazard_mflo_read got stall=%b use_hilo=%b hilo_out=%h expected 0 1 %h",
               stall, use_hilo, hilo_out, elo);
    end
    funct = 6'h10; #1;
    checks++;
    if (hilo_out !== ehi) begin
      errors++; $display("FAIL hazard_mfhi_read got %h expected %h", hilo_out, ehi);
    end
    @(negedge clk);
    funct = 6'h11; rs_val = 32'h0000_1234; #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL mthi_stall got %b expected 0", stall);
    end
    @(negedge clk);
    funct = 6'h13; rs_val = 32'hCAFE_0042; #1;
    checks++;
    if (hi !== 32'h0000_1234) begin
      errors++; $display("FAIL mthi_write got %h expected 00001234", hi);
    end
    go_idle(); #1;
    checks++;
    if (lo !== 32'hCAFE_0042 || hi !== 32'h0000_1234) begin
      errors++; $display("FAIL mtlo_write got hi=%h lo=%h expected 00001234 cafe0042", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int d1;
    do_md(6'h18, 32'h0000_1000, 32'h0000_0300, 0);
    d1 = last_done_cyc;
    do_md(6'h1A, 32'hFFFF_FF00, 32'h0000_0007, 0);
    checks++;
    if (last_done_cyc - d1 !== 35) begin
      errors++; $display("FAIL b2b_done_spacing got %0d expected 35", last_done_cyc - d1);
    end
    go_idle();
  endtask

  task automatic test_random();
    logic [5:0] f;
    logic [31:0] a, b;
    logic [1:0] sel;
    for (int i = 0; i < 24; i++) begin
      f = {4'b0110, 2'($urandom_range(0, 3))};
      sel = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case (sel)
        2'd0: b = 32'h0;
        2'd1: b = 32'hFFFF_FFFF;
        2'd2: b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      do_md(f, a, b, bit'($urandom_range(0, 1)));
    end
    go_idle();
  endtask

  task automatic test_reset_midop();
    bit saw_done;
    @(negedge clk);
    valid = 1'b1; aluop = 2'b10; funct = 6'h11; rs_val = 32'h5A5A_5A5A;
    @(negedge clk);
    funct = 6'h18; rs_val = 32'h1234_5678; rt_val = 32'h0000_0099;
    repeat (10) @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (stall !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midop_reset_ctrl got stall=%b done=%b expected 0 0", stall, done);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL midop_reset_hilo got hi=%h lo=%h expected 0 0", hi, lo);
    end
    rst = 1'b0;
    saw_done = 0;
    repeat (40) begin
      @(negedge clk); #1;
      if (done) saw_done = 1;
    end
    checks++;
    if (saw_done) begin
      errors++; $display("FAIL midop_no_done got a done pulse expected none");
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mult();
    test_div();
    test_hazard();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
